// File: rtl/whiteboard_cell_writer.sv
// whiteboard_cell_writer
//
// Write-side controller for the whiteboard cell RAM read by the VGA scan-out.
// Turns debounced direction buttons into a clamped cursor, issues one cell
// write per cycle while the pen is down (1 = black, 0 = white), and sweeps
// every cell to white when a clear is requested.
//
// Ports
//   clk                      pixel clock, the only clock
//   reset                    synchronous, active-high
//   move_up/down/left/right  debounced level buttons, active-high
//   pen_down                 level, cell writes enabled while high
//   erase_mode               level, 1 = write white (0), 0 = write black (1)
//   clear_request            level, rising edge starts a full-screen clear
//   cursor_x / cursor_y      current cursor cell (to the cursor overlay)
//   write_enable             cell write strobe
//   write_x / write_y        cell being written
//   write_data               cell value (1 = black)
//   busy                     high while the clear sweep is issuing writes
module whiteboard_cell_writer #(
    parameter int COLS          = 80,
    parameter int ROWS          = 60,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       pen_down,
    input  logic       erase_mode,
    input  logic       clear_request,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       write_enable,
    output logic [6:0] write_x,
    output logic [5:0] write_y,
    output logic       write_data,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [6:0]       X_LAST   = 7'(COLS - 1);
    localparam logic [5:0]       Y_LAST   = 6'(ROWS - 1);
    localparam logic [6:0]       X_MID    = 7'(COLS / 2);
    localparam logic [5:0]       Y_MID    = 6'(ROWS / 2);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [3:0]       btn_prev_q;
    logic             clr_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       cur_x_q, cur_x_d;
    logic [5:0]       cur_y_q, cur_y_d;
    logic             we_q, we_d;
    logic [6:0]       wx_q, wx_d;
    logic [5:0]       wy_q, wy_d;
    logic             wd_q, wd_d;
    logic             busy_q, busy_d;
    logic [6:0]       sx_q, sx_d;
    logic [5:0]       sy_q, sy_d;

    // Button vector order: {up, down, left, right}
    logic [3:0] btns;
    logic [3:0] rises;
    logic       clr_rise;
    logic       fire;
    logic       go_up, go_down, go_left, go_right;

    assign btns     = {move_up, move_down, move_left, move_right};
    assign rises    = btns & ~btn_prev_q;
    assign clr_rise = clear_request & ~clr_prev_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        we_d     = 1'b0;
        wx_d     = wx_q;
        wy_d     = wy_q;
        wd_d     = wd_q;
        busy_d   = 1'b0;
        sx_d     = sx_q;
        sy_d     = sy_q;
        fire     = 1'b0;
        go_up    = 1'b0;
        go_down  = 1'b0;
        go_left  = 1'b0;
        go_right = 1'b0;

        case (state_q)
            IDLE: begin
                // Auto-repeat: a fresh press restarts the hold timer so the
                // first repeat lands a full REPEAT_CYCLES after the press.
                if (|rises) begin
                    cnt_d = '0;
                end else if (|btns) begin
                    if (cnt_q == CNT_LAST) begin
                        fire  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end

                // Opposing buttons on one axis cancel, whether pressed or held.
                go_up    = move_up    & ~move_down  & (rises[3] | fire);
                go_down  = move_down  & ~move_up    & (rises[2] | fire);
                go_left  = move_left  & ~move_right & (rises[1] | fire);
                go_right = move_right & ~move_left  & (rises[0] | fire);

                if (go_up && cur_y_q != 6'd0) begin
                    cur_y_d = cur_y_q - 6'd1;
                end else if (go_down && cur_y_q != Y_LAST) begin
                    cur_y_d = cur_y_q + 6'd1;
                end

                if (go_left && cur_x_q != 7'd0) begin
                    cur_x_d = cur_x_q - 7'd1;
                end else if (go_right && cur_x_q != X_LAST) begin
                    cur_x_d = cur_x_q + 7'd1;
                end

                // A clear edge suppresses the pen write on the same cycle.
                if (clr_rise) begin
                    state_d = CLEAR;
                    sx_d    = 7'd0;
                    sy_d    = 6'd0;
                end else if (pen_down) begin
                    we_d = 1'b1;
                    wx_d = cur_x_q;
                    wy_d = cur_y_q;
                    wd_d = ~erase_mode;
                end
            end

            CLEAR: begin
                cnt_d  = '0;
                we_d   = 1'b1;
                wx_d   = sx_q;
                wy_d   = sy_q;
                wd_d   = 1'b0;
                busy_d = 1'b1;
                if (sx_q == X_LAST) begin
                    sx_d = 7'd0;
                    if (sy_q == Y_LAST) begin
                        state_d = IDLE;
                    end else begin
                        sy_d = sy_q + 6'd1;
                    end
                end else begin
                    sx_d = sx_q + 7'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            btn_prev_q <= 4'd0;
            clr_prev_q <= 1'b0;
            cnt_q      <= '0;
            cur_x_q    <= X_MID;
            cur_y_q    <= Y_MID;
            we_q       <= 1'b0;
            wx_q       <= 7'd0;
            wy_q       <= 6'd0;
            wd_q       <= 1'b0;
            busy_q     <= 1'b0;
            sx_q       <= 7'd0;
            sy_q       <= 6'd0;
        end else begin
            state_q    <= state_d;
            // Edge registers track in every state so a button held through
            // a clear does not look like a new press afterwards.
            btn_prev_q <= btns;
            clr_prev_q <= clear_request;
            cnt_q      <= cnt_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            we_q       <= we_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
        end
    end

    assign cursor_x     = cur_x_q;
    assign cursor_y     = cur_y_q;
    assign write_enable = we_q;
    assign write_x      = wx_q;
    assign write_y      = wy_q;
    assign write_data   = wd_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_whiteboard_cell_writer.sv
// Testbench for whiteboard_cell_writer, run with a short auto-repeat period.
module tb_whiteboard_cell_writer;

    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_up, move_down, move_left, move_right;
    logic       pen_down, erase_mode, clear_request;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic       write_enable;
    logic [6:0] write_x;
    logic [5:0] write_y;
    logic       write_data;
    logic       busy;

    int total  = 0;
    int passed = 0;

    whiteboard_cell_writer #(
        .COLS(80),
        .ROWS(60),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .move_up(move_up),
        .move_down(move_down),
        .move_left(move_left),
        .move_right(move_right),
        .pen_down(pen_down),
        .erase_mode(erase_mode),
        .clear_request(clear_request),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .write_enable(write_enable),
        .write_x(write_x),
        .write_y(write_y),
        .write_data(write_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        move_up = 0; move_down = 0; move_left = 0; move_right = 0;
        pen_down = 0; erase_mode = 0; clear_request = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cursor_x !== 7'd40) $display("FAIL reset_cursor_x: got %0d want 40", cursor_x); else passed++;
        total++; if (cursor_y !== 6'd30) $display("FAIL reset_cursor_y: got %0d want 30", cursor_y); else passed++;
        total++; if (write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", write_enable); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (write_x !== 7'd0 || write_y !== 6'd0 || write_data !== 1'b0)
            $display("FAIL reset_write_bus: got (%0d,%0d,%b) want (0,0,0)", write_x, write_y, write_data);
        else passed++;
    endtask

    task automatic test_single_press();
        do_reset();
        move_right = 1; tick(); move_right = 0;
        total++; if (cursor_x !== 7'd41) $display("FAIL press_1cycle: got %0d want 41", cursor_x); else passed++;
        tick();
        do_reset();
        move_right = 1;
        repeat (9) tick();
        move_right = 0;
        total++; if (cursor_x !== 7'd43) $display("FAIL press_9cycles: got %0d want 43", cursor_x); else passed++;
        tick();
        total++; if (cursor_x !== 7'd43) $display("FAIL release_no_step: got %0d want 43", cursor_x); else passed++;
        total++; if (cursor_y !== 6'd30) $display("FAIL press_y_static: got %0d want 30", cursor_y); else passed++;
    endtask

    task automatic test_clamp();
        do_reset();
        repeat (45) begin move_left = 1; tick(); move_left = 0; tick(); end
        total++; if (cursor_x !== 7'd0) $display("FAIL clamp_left: got %0d want 0", cursor_x); else passed++;
        repeat (35) begin move_down = 1; tick(); move_down = 0; tick(); end
        total++; if (cursor_y !== 6'd59) $display("FAIL clamp_down: got %0d want 59", cursor_y); else passed++;
        repeat (85) begin move_right = 1; tick(); move_right = 0; tick(); end
        total++; if (cursor_x !== 7'd79) $display("FAIL clamp_right: got %0d want 79", cursor_x); else passed++;
        repeat (65) begin move_up = 1; tick(); move_up = 0; tick(); end
        total++; if (cursor_y !== 6'd0) $display("FAIL clamp_up: got %0d want 0", cursor_y); else passed++;
    endtask

    task automatic test_draw();
        do_reset();
        pen_down = 1; erase_mode = 0; tick();
        total++; if (write_enable !== 1'b1 || write_x !== 7'd40 || write_y !== 6'd30 || write_data !== 1'b1)
            $display("FAIL draw_black: got we=%b (%0d,%0d) d=%b want we=1 (40,30) d=1",
                     write_enable, write_x, write_y, write_data);
        else passed++;
        erase_mode = 1; tick();
        total++; if (write_enable !== 1'b1 || write_data !== 1'b0)
            $display("FAIL draw_erase: got we=%b d=%b want we=1 d=0", write_enable, write_data);
        else passed++;
        erase_mode = 0; move_right = 1; tick(); move_right = 0;
        total++; if (write_x !== 7'd40 || cursor_x !== 7'd41)
            $display("FAIL draw_before_move: got write_x=%0d cursor_x=%0d want 40 41", write_x, cursor_x);
        else passed++;
        pen_down = 0; tick();
        total++; if (write_enable !== 1'b0) $display("FAIL pen_up: got %b want 0", write_enable); else passed++;
        move_up = 1; move_down = 1;
        repeat (10) tick();
        move_up = 0; move_down = 0;
        total++; if (cursor_y !== 6'd30) $display("FAIL up_down_cancel: got %0d want 30", cursor_y); else passed++;
        tick();
    endtask

    // Reference model: cursor advances on a press, then once every RC cycles
    // of uninterrupted holding counted from the latest press.
    task automatic test_random();
        int mx, my, run, ewx, ewy;
        bit ewe, ewd;
        bit [3:0] prev, b, rise;
        bit fire;
        int dx, dy;
        do_reset();
        mx = 40; my = 30; run = 0; prev = 0; ewx = 0; ewy = 0; ewe = 0; ewd = 0;
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            b   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                {move_up, move_down, move_left, move_right} = b;
                pen_down   = 1'($urandom_range(0, 1));
                erase_mode = 1'($urandom_range(0, 1));
                rise = b & ~prev;
                fire = 0;
                if (rise != 0) run = 0;
                else if (b != 0) begin run++; fire = (run % RC == 0); end
                else run = 0;
                ewe = pen_down;
                if (pen_down) begin ewx = mx; ewy = my; ewd = !erase_mode; end
                dx = int'(b[0]) - int'(b[1]);
                dy = int'(b[2]) - int'(b[3]);
                if (dx > 0 && (rise[0] || fire)) mx = (mx < 79) ? mx + 1 : 79;
                if (dx < 0 && (rise[1] || fire)) mx = (mx > 0) ? mx - 1 : 0;
                if (dy > 0 && (rise[2] || fire)) my = (my < 59) ? my + 1 : 59;
                if (dy < 0 && (rise[3] || fire)) my = (my > 0) ? my - 1 : 0;
                prev = b;
                tick();
                total++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my))
                    $display("FAIL rand_cursor seg %0d: got (%0d,%0d) want (%0d,%0d)", seg, cursor_x, cursor_y, mx, my);
                else passed++;
                total++; if (write_enable !== ewe)
                    $display("FAIL rand_we seg %0d: got %b want %b", seg, write_enable, ewe);
                else passed++;
                if (ewe) begin
                    total++; if (write_x !== 7'(ewx) || write_y !== 6'(ewy) || write_data !== ewd)
                        $display("FAIL rand_write seg %0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                                 seg, write_x, write_y, write_data, ewx, ewy, ewd);
                    else passed++;
                end
            end
        end
        zero_inputs();
        tick();
    endtask

    task automatic test_clear();
        int errs, first_bad, nwrites, nbusy;
        do_reset();
        pen_down = 1; move_right = 1; clear_request = 1;
        tick();
        total++; if (write_enable !== 1'b0 || busy !== 1'b0 || cursor_x !== 7'd41)
            $display("FAIL clear_edge_cycle: got we=%b busy=%b x=%0d want we=0 busy=0 x=41",
                     write_enable, busy, cursor_x);
        else passed++;
        errs = 0; first_bad = -1; nwrites = 0; nbusy = 0;
        for (int k = 0; k < 4800; k++) begin
            if (k < 4790) begin
                {move_up, move_down, move_left, move_right} = 4'($urandom_range(0, 15));
                pen_down      = 1'($urandom_range(0, 1));
                erase_mode    = 1'($urandom_range(0, 1));
                clear_request = 1'($urandom_range(0, 1));
            end else begin
                zero_inputs();
            end
            tick();
            nwrites += int'(write_enable);
            nbusy   += int'(busy);
            if (write_enable !== 1'b1 || write_x !== 7'(k % 80) || write_y !== 6'(k / 80) ||
                write_data !== 1'b0 || busy !== 1'b1 || cursor_x !== 7'd41 || cursor_y !== 6'd30) begin
                if (first_bad < 0) first_bad = k;
                errs++;
            end
        end
        total++; if (errs != 0)
            $display("FAIL clear_sweep: got %0d bad cycles (first at write %0d) want 0", errs, first_bad);
        else passed++;
        total++; if (nwrites != 4800) $display("FAIL clear_writes: got %0d want 4800", nwrites); else passed++;
        total++; if (write_x !== 7'd79 || write_y !== 6'd59)
            $display("FAIL clear_last_cell: got (%0d,%0d) want (79,59)", write_x, write_y);
        else passed++;
        tick();
        total++; if (busy !== 1'b0 || write_enable !== 1'b0)
            $display("FAIL clear_exit: got busy=%b we=%b want 0 0", busy, write_enable);
        else passed++;
        total++; if (nbusy != 4800) $display("FAIL clear_busy_len: got %0d want 4800", nbusy); else passed++;
        total++; if (cursor_x !== 7'd41 || cursor_y !== 6'd30)
            $display("FAIL clear_cursor_frozen: got (%0d,%0d) want (41,30)", cursor_x, cursor_y);
        else passed++;
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        clear_request = 1; tick(); clear_request = 0;
        repeat (101) tick();
        total++; if (write_x !== 7'd20 || write_y !== 6'd1 || busy !== 1'b1)
            $display("FAIL mid_clear_pos: got (%0d,%0d) busy=%b want (20,1) busy=1", write_x, write_y, busy);
        else passed++;
        reset = 1; tick(); reset = 0;
        total++; if (busy !== 1'b0 || write_enable !== 1'b0 || write_x !== 7'd0 || write_y !== 6'd0 ||
                     write_data !== 1'b0 || cursor_x !== 7'd40 || cursor_y !== 6'd30)
            $display("FAIL mid_clear_reset: got busy=%b we=%b (%0d,%0d,%b) cur=(%0d,%0d) want all reset values",
                     busy, write_enable, write_x, write_y, write_data, cursor_x, cursor_y);
        else passed++;
        tick();
        total++; if (busy !== 1'b0 || write_enable !== 1'b0)
            $display("FAIL mid_clear_stays_idle: got busy=%b we=%b want 0 0", busy, write_enable);
        else passed++;
        clear_request = 1; tick(); clear_request = 0;
        tick();
        total++; if (write_enable !== 1'b1 || write_x !== 7'd0 || write_y !== 6'd0 || busy !== 1'b1)
            $display("FAIL clear_restart: got we=%b (%0d,%0d) busy=%b want we=1 (0,0) busy=1",
                     write_enable, write_x, write_y, busy);
        else passed++;
        tick();
        total++; if (write_x !== 7'd1 || write_y !== 6'd0)
            $display("FAIL clear_restart_step: got (%0d,%0d) want (1,0)", write_x, write_y);
        else passed++;
    endtask

    initial begin
        reset = 1;
        zero_inputs();
        test_reset();
        test_single_press();
        test_clamp();
        test_draw();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
